// File: rtl/seq_counter_multiplier_if.sv
// Request/result bundle for seq_counter_multiplier: start request in,
// valid/ready result out, plus status and LED outputs.
interface seq_counter_multiplier_if #(
  parameter int WIDTH = 16,
  parameter int LED_W = 4
);
  logic               en;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic [LED_W-1:0]   led;

  modport slave (
    input  en,
    input  res_ready,
    output res_valid,
    output result,
    output busy,
    output led
  );

  modport master (
    output en,
    output res_ready,
    input  res_valid,
    input  result,
    input  busy,
    input  led
  );
endinterface

// File: rtl/seq_counter_multiplier.sv
// Two seeded counters feed an iterative shift-add multiplier (one bit per cycle);
// emits cnt_a*cnt_b+1 on a valid/ready port and mirrors its low bits onto the LEDs.
module seq_counter_multiplier #(
  parameter int WIDTH  = 16,
  parameter int SEED_A = 37,
  parameter int SEED_B = 42,
  parameter int LED_W  = 4
) (
  input logic clk,
  input logic rst,
  seq_counter_multiplier_if.slave bus
);
  localparam int RW     = 2 * WIDTH;
  localparam int ITER_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    cnt_a_reg, cnt_a_next;
  logic [WIDTH-1:0]    cnt_b_reg, cnt_b_next;
  logic [RW-1:0]       a_sh_reg, a_sh_next;
  logic [WIDTH-1:0]    b_sh_reg, b_sh_next;
  logic [RW-1:0]       acc_reg, acc_next;
  logic [ITER_W-1:0]   iter_reg, iter_next;
  logic [RW-1:0]       result_reg, result_next;
  logic [LED_W-1:0]    led_reg, led_next;

  logic [RW-1:0]       acc_sum;
  logic [RW-1:0]       result_sum;
  logic                start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_a_reg  <= WIDTH'(SEED_A);
      cnt_b_reg  <= WIDTH'(SEED_B);
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      acc_reg    <= '0;
      iter_reg   <= '0;
      result_reg <= '0;
      led_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_a_reg  <= cnt_a_next;
      cnt_b_reg  <= cnt_b_next;
      a_sh_reg   <= a_sh_next;
      b_sh_reg   <= b_sh_next;
      acc_reg    <= acc_next;
      iter_reg   <= iter_next;
      result_reg <= result_next;
      led_reg    <= led_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_a_next  = cnt_a_reg;
    cnt_b_next  = cnt_b_reg;
    a_sh_next   = a_sh_reg;
    b_sh_next   = b_sh_reg;
    acc_next    = acc_reg;
    iter_next   = iter_reg;
    result_next = result_reg;
    led_next    = led_reg;
    start       = 1'b0;

    acc_sum    = b_sh_reg[0] ? (acc_reg + a_sh_reg) : acc_reg;
    result_sum = acc_sum + RW'(1);

    case (state_reg)
      IDLE: begin
        if (bus.en) start = 1'b1;
      end
      MUL: begin
        a_sh_next = a_sh_reg << 1;
        b_sh_next = b_sh_reg >> 1;
        acc_next  = acc_sum;
        iter_next = iter_reg + ITER_W'(1);
        // This edge completes the last (WIDTH-th) partial product
        if (iter_reg == ITER_W'(WIDTH - 1)) begin
          result_next = result_sum;
          led_next    = result_sum[LED_W-1:0];
          state_next  = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_next = IDLE;
          if (bus.en) start = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Operand capture is shared by IDLE and the DONE handshake fast path
    if (start) begin
      a_sh_next  = {{WIDTH{1'b0}}, cnt_a_reg};
      b_sh_next  = cnt_b_reg;
      acc_next   = '0;
      iter_next  = '0;
      cnt_a_next = cnt_a_reg + WIDTH'(1);
      cnt_b_next = cnt_b_reg + WIDTH'(1);
      state_next = MUL;
    end
  end

  assign bus.res_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg == MUL);
  assign bus.result    = result_reg;
  assign bus.led       = led_reg;
endmodule

// File: doc/seq_counter_multiplier.md
Name: seq_counter_multiplier

Overview:
Parametrised successor to the free-running counter/multiplier LED demo. Two seeded WIDTH-bit counters supply operands to an iterative shift-add multiplier, one bit per cycle. The block emits product+1 through a valid/ready result port and drives an LED bus from the low result bits. It replaces the combinational multiplier path so wide configurations close timing on small FPGAs.

Parameters:
WIDTH, 16, operand/counter width; result is 2*WIDTH bits
SEED_A, 37, reset value of counter A
SEED_B, 42, reset value of counter B
LED_W, 4, LED bus width (LED_W <= 2*WIDTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk edge)
en  in  1  request: start one multiplication from the current counter values
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
result  out  2*WIDTH  cnt_a*cnt_b + 1 of the captured operands
busy  out  1  high while multiplying (state MUL)
led  out  LED_W  result[LED_W-1:0] of the most recent completed result

Behaviour:
- Reset (rst=0 at an edge): cnt_a=SEED_A, cnt_b=SEED_B, state IDLE, res_valid=0, result=0, busy=0, led=0. Reset mid-operation aborts; the partial product is discarded and no result is emitted.
- FSM states: IDLE, MUL, DONE.
- IDLE: en=1 at an edge -> capture a_sh=cnt_a, b_sh=cnt_b, acc=0, iter=0. Advance cnt_a, cnt_b by 1 (mod 2^WIDTH, wrap silently). Go to MUL. en=0 -> stay.
- MUL: each edge: if b_sh[0], acc += a_sh (2*WIDTH-bit); a_sh <<= 1; b_sh >>= 1; iter++. On the edge completing iteration WIDTH: result <= acc_next + 1, led <= (acc_next+1)[LED_W-1:0], res_valid <= 1, go to DONE. en is ignored in MUL and counters hold.
- Latency: acceptance at edge t -> res_valid high after edge t+WIDTH.
- Arithmetic: unsigned. +1 never overflows, since (2^W-1)^2+1 < 2^(2W). Counters wrap 2^W-1 -> 0.
- DONE: res_valid=1. result and led stay stable until the handshake (res_valid & res_ready at an edge).
  - Handshake with en=0 -> IDLE, res_valid=0.
  - Handshake with en=1 -> capture new operands and advance counters exactly as in IDLE, res_valid=0, go directly to MUL.
  - en=1 without res_ready -> ignored; counters do not advance.
- Throughput with en and res_ready held high: one result per WIDTH+1 cycles.
- led holds its value across IDLE/MUL and changes only when a new result is produced.
- busy = (state == MUL).

Test Plan:
- Default params, release reset, en=1 for one cycle, res_ready=1 -> res_valid rises 16 cycles after acceptance; result=0x00000613 (37*42+1=1555), led=0x3, busy high for exactly 16 cycles.
- Second request after the first handshake -> result=1635 (0x663, 38*43+1), led=0x3.
- Backpressure: res_ready=0 for 10 cycles with en=1 in DONE -> result/res_valid/led stable; counters still 38/43. After the handshake the next result is 38*43+1.
- Back-to-back: en=res_ready=1 continuously -> results 1555, 1635, 1717 (39*44+1) at a 17-cycle period, with no IDLE cycles between them.
- WIDTH=4, SEED_A=SEED_B=15, LED_W=4 -> first result 0xE2 (225+1), led=0x2; counters wrap to 0, so the second result is 0x01.
- Reset mid-operation: rst=0 during iteration 5 -> res_valid=0, busy=0, no result emitted. After release, the next request yields 1555 again.
